// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, LFSR constants and helpers for the Simon sequence player
package simon_pkg;

  localparam logic [15:0] LFSR_TAPS          = 16'hB400;
  localparam logic [15:0] RESET_SEED_DEFAULT = 16'hACE1;

  typedef logic [1:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_DONE
  } player_state_t;

  function automatic logic [3:0] onehot4(input colour_t c);
    onehot4 = 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// rtl/simon_lfsr16.sv - 16-bit Galois LFSR with synchronous load; load wins over step
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = RESET_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/simon_sequence_player.sv
// rtl/simon_sequence_player.sv - replays the seeded colour sequence on the lamps and
// tracks the expected colour for the input checker
module simon_sequence_player
  import simon_pkg::*;
#(
  parameter int          MAX_LEN    = 32,
  parameter int          ON_TICKS   = 4,
  parameter int          OFF_TICKS  = 2,
  parameter logic [15:0] RESET_SEED = RESET_SEED_DEFAULT,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int TCNT_W = $clog2(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             new_game,
  input  logic             start_play,
  input  logic [LEN_W-1:0] len,
  input  logic             exp_rewind,
  input  logic             exp_advance,
  output logic [3:0]       led,
  output logic             tone_en,
  output logic [1:0]       tone_sel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       exp_color
);

  localparam logic [LEN_W-1:0]  MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [TCNT_W-1:0] ON_END    = TCNT_W'(ON_TICKS - 1);
  localparam logic [TCNT_W-1:0] OFF_END   = TCNT_W'(OFF_TICKS - 1);

  player_state_t    state, state_n;
  logic [15:0]      seed, capture, free_q, play_q, exp_q;
  logic [LEN_W-1:0] len_q, len_n, len_clamped, idx, idx_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic             play_load, play_step, seed_load;
  logic             unused_bits;

  assign len_clamped = (len > MAX_LEN_W) ? MAX_LEN_W : len;
  // A Galois LFSR never reaches zero from a nonzero state; the substitute is defensive
  assign capture     = (free_q == 16'h0000) ? RESET_SEED : free_q;
  assign seed_load   = new_game && (state == ST_IDLE);
  assign exp_color   = exp_q[1:0];
  assign unused_bits = ^{play_q[15:2], exp_q[15:2]};

  simon_lfsr16 #(.RESET_VAL(RESET_SEED)) u_free_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (16'h0000),
    .step     (1'b1),
    .q        (free_q)
  );

  simon_lfsr16 #(.RESET_VAL(RESET_SEED)) u_play_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (play_load),
    .load_val (seed),
    .step     (play_step),
    .q        (play_q)
  );

  // A fresh game also points the checker back at element 0 of the new sequence
  simon_lfsr16 #(.RESET_VAL(RESET_SEED)) u_exp_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load || exp_rewind),
    .load_val (seed_load ? capture : seed),
    .step     (exp_advance),
    .q        (exp_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      seed  <= RESET_SEED;
      len_q <= '0;
      idx   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      idx   <= idx_n;
      tcnt  <= tcnt_n;
      if (seed_load) begin
        seed <= capture;
      end
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    idx_n     = idx;
    tcnt_n    = tcnt;
    play_load = 1'b0;
    play_step = 1'b0;
    led       = 4'b0000;
    tone_en   = 1'b0;
    tone_sel  = 2'b00;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_play) begin
          len_n  = len_clamped;
          idx_n  = '0;
          tcnt_n = '0;
          if (len_clamped == '0) begin
            state_n = ST_DONE;
          end else begin
            play_load = 1'b1;
            state_n   = ST_ON;
          end
        end
      end

      ST_ON: begin
        led      = onehot4(play_q[1:0]);
        tone_en  = 1'b1;
        tone_sel = play_q[1:0];
        if (tick) begin
          if (tcnt == ON_END) begin
            tcnt_n  = '0;
            state_n = ST_OFF;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_OFF: begin
        if (tick) begin
          if (tcnt == OFF_END) begin
            tcnt_n = '0;
            if (idx == len_q - 1'b1) begin
              state_n = ST_DONE;
            end else begin
              idx_n     = idx + 1'b1;
              play_step = 1'b1;
              state_n   = ST_ON;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
